// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM encoding, PPROT bit positions and clog2 helper for the APB4 master.
package apb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DERR = 2'd3} state_t;
  localparam int PPROT_PRIV  = 0;
  localparam int PPROT_NSEC  = 1;
  localparam int PPROT_INSTR = 2;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/apb_addr_decoder.sv
// apb_addr_decoder: maps the slave index field of an address to a one-hot select.
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_SLV    = 4,
  parameter int SEL_LSB    = 12
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [NUM_SLV-1:0]    sel,
  output logic                  decode_err
);
  localparam int SEL_W = clog2(NUM_SLV) > 1 ? clog2(NUM_SLV) : 1;
  logic [SEL_W-1:0] idx;
  logic unused_addr;
  assign idx = addr[SEL_LSB +: SEL_W];
  assign unused_addr = ^addr;
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLV; i++) sel[i] = idx == SEL_W'(i);
  end
  // an index past the last slave selects nothing
  assign decode_err = ~|sel;
endmodule

// File: rtl/apb4_multi_master.sv
// apb4_multi_master: valid/ready request port to APB4 with integrated slave decode.
// Define APB4_MULTI_MASTER_TIMEOUT_EN to abort ACCESS phases after TIMEOUT_CYC wait cycles.
module apb4_multi_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_SLV     = 4,
  parameter int SEL_LSB     = 12,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                          pclock,
  input  logic                          presetn,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [DATA_WIDTH-1:0]         req_wdata,
  input  logic [DATA_WIDTH/8-1:0]       req_strb,
  input  logic [2:0]                    req_prot,
  output logic                          rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [NUM_SLV-1:0]            psel,
  output logic                          penable,
  output logic                          pwrite,
  output logic [ADDR_WIDTH-1:0]         paddr,
  output logic [DATA_WIDTH-1:0]         pwdata,
  output logic [DATA_WIDTH/8-1:0]       pstrb,
  output logic [2:0]                    pprot,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] prdata,
  input  logic [NUM_SLV-1:0]            pready,
  input  logic [NUM_SLV-1:0]            pslverr
);
  state_t state, state_n;
  logic [NUM_SLV-1:0] dsel;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic derr, done, sel_err, accept, load, timeout;
  apb_addr_decoder #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_SLV(NUM_SLV), .SEL_LSB(SEL_LSB)) u_dec (
    .addr(req_addr),
    .sel(dsel),
    .decode_err(derr)
  );
  // psel is one-hot, so it doubles as the response mux select
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) sel_rdata |= psel[i] ? prdata[i*DATA_WIDTH +: DATA_WIDTH] : '0;
  end
  assign done      = state == ACCESS && |(pready & psel);
  assign sel_err   = |(pslverr & psel);
  assign req_ready = state == IDLE || done;
  assign accept    = req_valid && req_ready;
  assign load      = accept && !derr;
`ifdef APB4_MULTI_MASTER_TIMEOUT_EN
  localparam int TW0 = clog2(TIMEOUT_CYC + 1);
  localparam int TW  = TW0 < 8 ? 8 : TW0 > 16 ? 16 : TW0;
  logic [TW-1:0] to_cnt;
  always_ff @(posedge pclock or negedge presetn) begin
    if (!presetn) to_cnt <= '0;
    else if (state == SETUP) to_cnt <= '0;
    else if (state == ACCESS && !done) to_cnt <= to_cnt + 1'b1;
  end
  assign timeout = state == ACCESS && !done && to_cnt == TW'(TIMEOUT_CYC - 1);
`else
  localparam int unused_timeout = TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_n = accept ? (derr ? DERR : SETUP) :
              state == SETUP ? ACCESS :
              state == ACCESS && !done && !timeout ? ACCESS : IDLE;
  end
  always_ff @(posedge pclock or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge pclock or negedge presetn) begin
    if (!presetn) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      pprot     <= '0;
    end else begin
      rsp_valid <= done || timeout || state == DERR;
      rsp_err   <= done ? sel_err : (timeout || state == DERR);
      rsp_rdata <= done && !pwrite && !sel_err ? sel_rdata : '0;
      if (load) begin
        psel               <= dsel;
        penable            <= 1'b0;
        pwrite             <= req_write;
        paddr              <= req_addr;
        pwdata             <= req_write ? req_wdata : '0;
        pstrb              <= req_write ? req_strb : '0;
        pprot[PPROT_PRIV]  <= req_prot[PPROT_PRIV];
        pprot[PPROT_NSEC]  <= req_prot[PPROT_NSEC];
        pprot[PPROT_INSTR] <= req_prot[PPROT_INSTR];
      end else if (state_n == ACCESS) begin
        penable <= 1'b1;
      end else begin
        psel    <= '0;
        penable <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_apb4_multi_master.sv
// tb_apb4_multi_master: directed and randomized checks of the APB4 master against a transaction-level model.
module tb_apb4_multi_master;
  localparam int NS = 3;
  logic        pclock = 1'b0;
  logic        presetn = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic [2:0]  req_prot = '0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [NS-1:0] psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [NS*32-1:0] prdata = '0;
  logic [NS-1:0] pready = '0, pslverr = '0;
  int total = 0, bad = 0;

  apb4_multi_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_SLV(NS), .SEL_LSB(12), .TIMEOUT_CYC(16)) dut (
    .pclock(pclock), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclock = ~pclock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Issues one request and plays the addressed slave (waits stall cycles, then pready),
  // with random noise on every unselected slave. Only observes; callers compare.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [2:0] p, input int waits, input logic se, input logic [31:0] rd,
                      output int lat, output logic err, output logic [31:0] rdat, output logic [NS-1:0] sel_or,
                      output logic [31:0] pa, output logic [31:0] pwd, output logic [3:0] pst,
                      output logic pw, output logic [2:0] pp, output logic stable);
    int acc, idx;
    logic [NS-1:0] snap_sel;
    idx = int'(a[13:12]);
    lat = -1; err = 1'b0; rdat = '0; sel_or = '0; stable = 1'b1; acc = 0;
    pa = '0; pwd = '0; pst = '0; pw = 1'b0; pp = '0; snap_sel = '0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_strb = s; req_prot = p;
    for (int n = 1; n <= 60; n++) begin
      @(negedge pclock);
      req_valid = 1'b0;
      if (rsp_valid) begin
        lat = n; err = rsp_err; rdat = rsp_rdata;
        break;
      end
      sel_or |= psel;
      if ($countones(psel) > 1) stable = 1'b0;
      if (psel != '0 && !penable) begin
        snap_sel = psel; pa = paddr; pwd = pwdata; pst = pstrb; pw = pwrite; pp = pprot;
      end else if (psel != '0) begin
        if ({psel, paddr, pwdata, pstrb, pwrite, pprot} !== {snap_sel, pa, pwd, pst, pw, pp}) stable = 1'b0;
      end
      pready = NS'($urandom); pslverr = NS'($urandom); prdata = {$urandom, $urandom, $urandom};
      if (psel != '0 && penable) begin
        if (idx < NS) begin
          pready[idx] = acc >= waits;
          pslverr[idx] = se;
          prdata[idx*32 +: 32] = rd;
        end
        acc++;
      end
    end
    pready = '0; pslverr = '0; prdata = '0;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    @(negedge pclock);
    total++;
    if ({psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
      bad++;
      $display("FAIL reset_outputs psel=%b penable=%b paddr=%h rsp_valid=%b (all must be 0)", psel, penable, paddr, rsp_valid);
    end
    presetn = 1'b1;
    @(negedge pclock);
  endtask

  task automatic test_write();
    int lat; logic err, pw, st; logic [31:0] rd, pa, pwd; logic [3:0] pst; logic [2:0] pp; logic [NS-1:0] so;
    xfer(1'b1, 32'h0000_1000, 32'hA5A5_0001, 4'hF, 3'b010, 0, 1'b0, 32'h0, lat, err, rd, so, pa, pwd, pst, pw, pp, st);
    total++; if (lat !== 3) begin bad++; $display("FAIL wr_latency got=%0d exp=3", lat); end
    total++; if (so !== 3'b010) begin bad++; $display("FAIL wr_psel got=%b exp=010", so); end
    total++; if (pst !== 4'hF) begin bad++; $display("FAIL wr_pstrb got=%h exp=f", pst); end
    total++; if ({pwd, pa, pw, pp} !== {32'hA5A5_0001, 32'h0000_1000, 1'b1, 3'b010}) begin
      bad++; $display("FAIL wr_fields pwdata=%h paddr=%h pwrite=%b pprot=%b", pwd, pa, pw, pp); end
    total++; if ({err, rd} !== 33'h0) begin bad++; $display("FAIL wr_rsp err=%b rdata=%h exp 0/0", err, rd); end
  endtask

  task automatic test_read_wait();
    int lat; logic err, pw, st; logic [31:0] rd, pa, pwd; logic [3:0] pst; logic [2:0] pp; logic [NS-1:0] so;
    xfer(1'b0, 32'h0000_2004, 32'h1234_5678, 4'h5, 3'b001, 4, 1'b0, 32'hDEAD_BEEF, lat, err, rd, so, pa, pwd, pst, pw, pp, st);
    total++; if (lat !== 7) begin bad++; $display("FAIL rdw_latency got=%0d exp=7", lat); end
    total++; if (rd !== 32'hDEAD_BEEF || err !== 1'b0) begin bad++; $display("FAIL rdw_data got=%h err=%b exp=deadbeef/0", rd, err); end
    total++; if ({pst, pwd} !== 36'h0) begin bad++; $display("FAIL rdw_strb_wdata pstrb=%h pwdata=%h exp 0", pst, pwd); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL rdw_stable got=%b exp=1", st); end
    total++; if ({so, pa} !== {3'b100, 32'h0000_2004}) begin bad++; $display("FAIL rdw_sel psel=%b paddr=%h", so, pa); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rv;
    rv = $urandom;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_strb = 4'h0; req_prot = 3'b000;
    @(negedge pclock);
    req_write = 1'b1; req_addr = 32'h0000_1008; req_wdata = 32'h0BAD_F00D; req_strb = 4'h3;
    #1;
    total++; if ({psel, penable, req_ready} !== {3'b001, 1'b0, 1'b0}) begin
      bad++; $display("FAIL b2b_setup1 psel=%b penable=%b req_ready=%b exp 001/0/0", psel, penable, req_ready); end
    @(negedge pclock);
    pready[0] = 1'b1; prdata[31:0] = rv;
    #1;
    total++; if ({penable, req_ready} !== 2'b11) begin bad++; $display("FAIL b2b_access1 penable=%b req_ready=%b exp 1/1", penable, req_ready); end
    @(negedge pclock);
    req_valid = 1'b0; pready = '0; prdata = '0;
    total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, rv}) begin
      bad++; $display("FAIL b2b_rsp1 valid=%b err=%b rdata=%h exp 1/0/%h", rsp_valid, rsp_err, rsp_rdata, rv); end
    total++; if ({psel, penable, pwrite, paddr} !== {3'b010, 1'b0, 1'b1, 32'h0000_1008}) begin
      bad++; $display("FAIL b2b_setup2 psel=%b penable=%b pwrite=%b paddr=%h", psel, penable, pwrite, paddr); end
    @(negedge pclock);
    total++; if ({rsp_valid, penable} !== 2'b01) begin bad++; $display("FAIL b2b_gap rsp_valid=%b penable=%b exp 0/1", rsp_valid, penable); end
    pready[1] = 1'b1;
    @(negedge pclock);
    pready = '0;
    total++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL b2b_rsp2 valid=%b err=%b rdata=%h exp 1/0/0", rsp_valid, rsp_err, rsp_rdata); end
  endtask

  task automatic test_decode_err();
    int lat; logic err, pw, st; logic [31:0] rd, pa, pwd; logic [3:0] pst; logic [2:0] pp; logic [NS-1:0] so;
    xfer(1'b0, 32'h0000_3000, 32'h0, 4'h0, 3'b000, 0, 1'b0, 32'hFFFF_FFFF, lat, err, rd, so, pa, pwd, pst, pw, pp, st);
    total++; if (so !== 3'b000) begin bad++; $display("FAIL derr_psel got=%b exp=000", so); end
    total++; if ({lat, err, rd} !== {32'd2, 1'b1, 32'h0}) begin bad++; $display("FAIL derr_rsp lat=%0d err=%b rdata=%h exp 2/1/0", lat, err, rd); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL derr_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_slverr();
    int lat; logic err, pw, st; logic [31:0] rd, pa, pwd; logic [3:0] pst; logic [2:0] pp; logic [NS-1:0] so;
    xfer(1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'b100, 1, 1'b1, 32'h5555_AAAA, lat, err, rd, so, pa, pwd, pst, pw, pp, st);
    total++; if ({lat, err, rd} !== {32'd4, 1'b1, 32'h0}) begin bad++; $display("FAIL slverr_rsp lat=%0d err=%b rdata=%h exp 4/1/0", lat, err, rd); end
  endtask

  task automatic test_reset_mid_access();
    logic seen;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0; req_prot = 3'b000;
    @(negedge pclock);
    req_valid = 1'b0;
    @(negedge pclock);
    total++; if ({psel, penable} !== {3'b001, 1'b1}) begin bad++; $display("FAIL rstm_access psel=%b penable=%b exp 001/1", psel, penable); end
    #2 presetn = 1'b0;
    #1;
    total++; if ({psel, penable} !== 4'b0) begin bad++; $display("FAIL rstm_drop psel=%b penable=%b exp 0/0", psel, penable); end
    pready = '1;
    @(negedge pclock);
    presetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge pclock);
      seen |= rsp_valid;
    end
    pready = '0;
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstm_no_rsp rsp_valid seen=%b exp=0", seen); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rstm_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_timeout();
`ifdef APB4_MULTI_MASTER_TIMEOUT_EN
    int lat; logic err, pw, st; logic [31:0] rd, pa, pwd; logic [3:0] pst; logic [2:0] pp; logic [NS-1:0] so;
    xfer(1'b0, 32'h0000_1000, 32'h0, 4'h0, 3'b000, 1000, 1'b0, 32'h1111_2222, lat, err, rd, so, pa, pwd, pst, pw, pp, st);
    total++; if ({lat, err, rd} !== {32'd18, 1'b1, 32'h0}) begin bad++; $display("FAIL timeout_rsp lat=%0d err=%b rdata=%h exp 18/1/0", lat, err, rd); end
    total++; if ({psel, penable, req_ready} !== {3'b000, 1'b0, 1'b1}) begin
      bad++; $display("FAIL timeout_idle psel=%b penable=%b req_ready=%b exp 0/0/1", psel, penable, req_ready); end
`endif
  endtask

  task automatic test_random();
    int lat, idx, waits, exp_lat; logic err, pw, st, w, se, is_bad; logic [31:0] rd, pa, pwd, a, d, rv, exp_rd;
    logic [3:0] pst, s; logic [2:0] pp, p; logic [NS-1:0] so, exp_sel;
    for (int k = 0; k < 30; k++) begin
      idx = $urandom_range(0, 3);
      a = ($urandom & ~32'h3000) | (32'(idx) << 12);
      w = 1'($urandom); d = $urandom; s = 4'($urandom); p = 3'($urandom);
      waits = $urandom_range(0, 3); se = ($urandom_range(0, 3) == 0); rv = $urandom;
      xfer(w, a, d, s, p, waits, se, rv, lat, err, rd, so, pa, pwd, pst, pw, pp, st);
      is_bad = idx >= NS;
      exp_lat = is_bad ? 2 : 3 + waits;
      exp_sel = is_bad ? '0 : NS'(1 << idx);
      exp_rd = (!w && !is_bad && !se) ? rv : 32'h0;
      total++;
      if (lat !== exp_lat || err !== (is_bad || se) || rd !== exp_rd || so !== exp_sel) begin
        bad++;
        $display("FAIL rnd_rsp k=%0d lat=%0d/%0d err=%b/%b rdata=%h/%h psel=%b/%b", k, lat, exp_lat, err, is_bad || se, rd, exp_rd, so, exp_sel);
      end
      if (!is_bad) begin
        total++;
        if (pa !== a || pw !== w || pp !== p || pwd !== (w ? d : 32'h0) || pst !== (w ? s : 4'h0) || st !== 1'b1) begin
          bad++;
          $display("FAIL rnd_bus k=%0d paddr=%h/%h pwrite=%b/%b pprot=%b/%b pwdata=%h pstrb=%h stable=%b", k, pa, a, pw, w, pp, p, pwd, pst, st);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_back_to_back();
    test_decode_err();
    test_slverr();
    test_reset_mid_access();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
